lfsr_prbs_checker: RTL and testbench

//  Receive end of the LFSR pattern path: checks a serial PRBS bit stream from an 8-bit

---
 rtl/lfsr_prbs_checker.sv | 170 +++++++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_checker.sv
// PRBS receive checker for an 8-bit Fibonacci LFSR stream: hunt, verify, lock, error count, hex display.
// Define CHK_SEG_EN to build the 7-segment decoder; otherwise seg0_o/seg1_o are tied to all-off.
module lfsr_prbs_checker #(
  parameter logic [7:0] TAPS     = 8'h1D,
  parameter int         LOCK_CNT = 16,
  parameter int         LOSS_ERR = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        din_i,
  input  logic        din_vld_i,
  input  logic        clr_i,
  output logic        locked_o,
  output logic        err_pls_o,
  output logic [15:0] err_cnt_o,
  output logic [1:0]  state_o,
  output logic [7:0]  seg0_o,
  output logic [7:0]  seg1_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int CW = $clog2(LOSS_ERR + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t          state_q;
  logic [7:0]      shadow_q;
  logic [3:0]      fill_q;
  logic [MW-1:0]   match_q;
  logic [CW-1:0]   cerr_q;
  logic [15:0]     err_cnt_q;
  logic [15:0]     err_cnt_d;
  logic            locked_q;
  logic            err_pls_q;

  logic            pred;
  logic [7:0]      shift_din;
  logic [3:0]      fill_inc;
  logic [MW-1:0]   match_inc;
  logic            err_evt;

  assign pred      = ^(shadow_q & TAPS);
  assign shift_din = {din_i, shadow_q[7:1]};
  assign fill_inc  = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
  assign match_inc = match_q + MW'(1);
  assign err_evt   = din_vld_i && (state_q == LOCKED) && (din_i != pred);

  // Clear wins over a simultaneous error; the pulse still fires from err_evt.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_i) begin
      err_cnt_d = '0;
    end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= HUNT;
      shadow_q  <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      cerr_q    <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      err_pls_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_pls_q <= err_evt;
      if (din_vld_i) begin
        case (state_q)
          HUNT: begin
            shadow_q <= shift_din;
            fill_q   <= fill_inc;
            if ((fill_inc == 4'd8) && (shift_din != 8'h00)) begin
              state_q <= VERIFY;
              match_q <= '0;
            end
          end
          VERIFY: begin
            shadow_q <= shift_din;
            if (din_i == pred) begin
              match_q <= match_inc;
              if (match_inc == MW'(LOCK_CNT)) begin
                state_q  <= LOCKED;
                cerr_q   <= '0;
                locked_q <= 1'b1;
              end
            end else begin
              match_q <= '0;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so one corrupted bit is counted exactly once.
            shadow_q <= {pred, shadow_q[7:1]};
            if (din_i == pred) begin
              cerr_q <= '0;
            end else begin
              cerr_q <= cerr_q + CW'(1);
              if (cerr_q == CW'(LOSS_ERR - 1)) begin
                state_q  <= HUNT;
                fill_q   <= '0;
                shadow_q <= '0;
                locked_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  assign locked_o  = locked_q;
  assign err_pls_o = err_pls_q;
  assign err_cnt_o = err_cnt_q;
  assign state_o   = state_q;

`ifdef CHK_SEG_EN
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  logic [7:0] seg0_q;
  logic [7:0] seg1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg0_q <= 8'h03;
      seg1_q <= 8'h03;
    end else begin
      seg0_q <= hex7(err_cnt_q[3:0]);
      seg1_q <= hex7(err_cnt_q[7:4]);
    end
  end

  assign seg0_o = seg0_q;
  assign seg1_o = seg1_q;
`else
  assign seg0_o = 8'hFF;
  assign seg1_o = 8'hFF;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: directed scenarios plus a randomized stream, all checked every cycle
// against a sequence-level model of the hunt/verify/lock rules.
module tb_lfsr_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_vld = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic        err_pls;
  logic [15:0] err_cnt;
  logic [1:0]  state;
  logic [7:0]  seg0;
  logic [7:0]  seg1;

  always #5 clk = ~clk;

  lfsr_prbs_checker dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .din_i     (din),
    .din_vld_i (din_vld),
    .clr_i     (clr),
    .locked_o  (locked),
    .err_pls_o (err_pls),
    .err_cnt_o (err_cnt),
    .state_o   (state),
    .seg0_o    (seg0),
    .seg1_o    (seg1)
  );

`ifdef CHK_SEG_EN
  localparam logic [7:0] L03 = 8'h03;
  localparam logic [7:0] L9F = 8'h9F;
  localparam logic [7:0] L25 = 8'h25;
  logic [7:0] hexmap [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
`else
  localparam logic [7:0] L03 = 8'hFF;
  localparam logic [7:0] L9F = 8'hFF;
  localparam logic [7:0] L25 = 8'hFF;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pls_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int nib);
`ifdef CHK_SEG_EN
    return hexmap[nib & 15];
`else
    return 8'hFF;
`endif
  endfunction

  // Model: the reference history is the last 8 bits the checker believes in (oldest first).
  bit         hist [8];
  int         m_mode;
  int         m_fill;
  int         m_match;
  int         m_cerr;
  int         m_cnt;
  bit         m_locked;
  bit         m_pls;
  logic [7:0] m_seg0;
  logic [7:0] m_seg1;

  function automatic bit hist_pred();
    return hist[0] ^ hist[2] ^ hist[3] ^ hist[4];
  endfunction

  function automatic bit hist_nonzero();
    bit r = 1'b0;
    for (int i = 0; i < 8; i++) r |= hist[i];
    return r;
  endfunction

  task automatic hist_push(input bit b);
    for (int i = 0; i < 7; i++) hist[i] = hist[i+1];
    hist[7] = b;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    m_mode = 0; m_fill = 0; m_match = 0; m_cerr = 0; m_cnt = 0;
    m_locked = 1'b0; m_pls = 1'b0;
    m_seg0 = seg_of(0); m_seg1 = seg_of(0);
  endtask

  always @(posedge clk) begin
    logic [7:0] s0n;
    logic [7:0] s1n;
    bit p;
    if (!rst_n) begin
      model_reset();
    end else begin
      s0n = seg_of(m_cnt & 15);
      s1n = seg_of((m_cnt >> 4) & 15);
      m_pls = 1'b0;
      if (din_vld) begin
        if (m_mode == 0) begin
          hist_push(din);
          if (m_fill < 8) m_fill++;
          if (m_fill == 8 && hist_nonzero()) begin
            m_mode = 1; m_match = 0;
          end
        end else if (m_mode == 1) begin
          p = hist_pred();
          hist_push(din);
          if (din == p) begin
            m_match++;
            if (m_match == 16) begin m_mode = 2; m_cerr = 0; end
          end else begin
            m_match = 0;
          end
        end else begin
          p = hist_pred();
          hist_push(p);
          if (din == p) begin
            m_cerr = 0;
          end else begin
            m_pls = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            m_cerr++;
            if (m_cerr == 4) begin
              m_mode = 0; m_fill = 0;
              for (int i = 0; i < 8; i++) hist[i] = 1'b0;
            end
          end
        end
      end
      if (clr) m_cnt = 0;
      m_locked = (m_mode == 2);
      m_seg0 = s0n;
      m_seg1 = s1n;
    end
  end

  always @(negedge clk) begin
    chk("locked",  locked,  m_locked);
    chk("err_pls", err_pls, m_pls);
    chk("err_cnt", err_cnt, m_cnt);
    chk("state",   state,   m_mode);
    chk("seg0",    seg0,    m_seg0);
    chk("seg1",    seg1,    m_seg1);
    if (err_pls === 1'b1) pls_seen++;
  end

  // Generator: s[n+8] = s[n]^s[n+2]^s[n+3]^s[n+4], seed bit i = s[i].
  bit g [8];
  int bitno   = 0;
  int flip_lo = -1;
  int flip_hi = -1;

  task automatic gen_seed(input logic [7:0] s);
    for (int i = 0; i < 8; i++) g[i] = s[i];
  endtask

  task automatic gen_bit(output bit b);
    bit nb;
    b  = g[0];
    nb = g[0] ^ g[2] ^ g[3] ^ g[4];
    for (int i = 0; i < 7; i++) g[i] = g[i+1];
    g[7] = nb;
  endtask

  task automatic cyc(input bit d, input bit v, input bit c);
    @(negedge clk);
    din = d; din_vld = v; clr = c;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit c);
    bit b;
    bitno++;
    gen_bit(b);
    if (bitno >= flip_lo && bitno <= flip_hi) b = ~b;
    cyc(b, 1'b1, c);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    bit b;
    int rise;
    int burst;
    bit v;
    bit c;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_locked",  locked,  0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_state",   state,   0);
    chk("rst_seg0",    seg0,    L03);
    chk("rst_seg1",    seg1,    L03);
    rst_n = 1'b1;

    // 1: clean stream from seed 01 locks after bit 24
    gen_seed(8'h01);
    bitno = 0;
    send_bits(23);
    settle();
    chk("t1_locked_bit23", locked, 0);
    chk("t1_state_bit23",  state,  1);
    send_bits(1);
    settle();
    chk("t1_locked_bit24", locked,  1);
    chk("t1_state_bit24",  state,   2);
    chk("t1_err_cnt",      err_cnt, 0);
    chk("t1_seg0",         seg0,    L03);
    chk("t1_seg1",         seg1,    L03);

    // 2: single flipped bit 100 counts once
    pls_seen = 0;
    flip_lo = 100; flip_hi = 100;
    send_bits(106);
    settle();
    chk("t2_pulses",  pls_seen, 1);
    chk("t2_err_cnt", err_cnt,  1);
    chk("t2_seg0",    seg0,     L9F);
    chk("t2_locked",  locked,   1);

    // 3: clear, then 4 consecutive flips drop lock; relock 24 bits later
    send_bit(1'b1);
    flip_lo = 132; flip_hi = 135;
    send_bits(3);
    settle();
    chk("t3_locked_after3", locked, 1);
    send_bits(1);
    settle();
    chk("t3_err_cnt",       err_cnt, 4);
    chk("t3_locked_after4", locked,  0);
    chk("t3_state_hunt",    state,   0);
    send_bits(23);
    settle();
    chk("t3_relock_bit23", locked, 0);
    send_bits(1);
    settle();
    chk("t3_relock_bit24", locked, 1);

    // 4: all-zero input never leaves HUNT
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b0);
    settle();
    chk("t4_state",   state,   0);
    chk("t4_locked",  locked,  0);
    chk("t4_err_cnt", err_cnt, 0);

    // 5: valid every other cycle; garbage on invalid cycles must be ignored
    do_reset();
    gen_seed(8'h01);
    rise = -1;
    for (int i = 0; i < 48; i++) begin
      if (i % 2 == 0) begin
        gen_bit(b);
        cyc(b, 1'b1, 1'b0);
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      settle();
      if (locked === 1'b1 && rise < 0) rise = i;
    end
    chk("t5_lock_cycle", rise,    46);
    chk("t5_err_cnt",    err_cnt, 0);
    chk("t5_state",      state,   2);

    // 6: saturation at FFFF, clear, then async reset while locked
    @(negedge clk);
    #1;
    force dut.err_cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    din_vld = 1'b0; clr = 1'b0;
    @(negedge clk);
    #1;
    release dut.err_cnt_q;
    for (int i = 0; i < 3; i++) begin
      gen_bit(b);
      cyc(~b, 1'b1, 1'b0);
    end
    settle();
    chk("t6_saturate", err_cnt, 16'hFFFF);
    chk("t6_locked",   locked,  1);
    gen_bit(b);
    cyc(b, 1'b1, 1'b1);
    settle();
    chk("t6_clr", err_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      gen_bit(b);
      cyc((i < 2) ? ~b : b, 1'b1, 1'b0);
    end
    settle();
    @(negedge clk);
    din_vld = 1'b0;
    chk("t6_pre_rst_cnt",  err_cnt, 2);
    chk("t6_pre_rst_seg0", seg0,    L25);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_locked",  locked,  0);
    chk("t6_arst_err_pls", err_pls, 0);
    chk("t6_arst_err_cnt", err_cnt, 0);
    chk("t6_arst_state",   state,   0);
    chk("t6_arst_seg0",    seg0,    L03);
    chk("t6_arst_seg1",    seg1,    L03);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized stream: random valid gaps, error bursts and occasional clears
    gen_seed(8'($urandom_range(1, 255)));
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = v && ($urandom_range(0, 199) == 0);
      if (v) begin
        gen_bit(b);
        if (burst == 0 && $urandom_range(0, 63) == 0) burst = $urandom_range(1, 5);
        if (burst > 0) begin
          b = ~b;
          burst--;
        end
        cyc(b, 1'b1, c);
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
